// File: rtl/apb_req_mgr.sv
// rtl/apb_req_mgr.sv - APB3 manager: single-outstanding valid/ready request to APB SETUP/ACCESS bridge
// Optional ACCESS-phase timeout is compiled in with `define APB_MGR_TIMEOUT_EN.
module apb_req_mgr #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_we_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic [AddrWidth-1:0] paddr_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [DataWidth-1:0] pwdata_o,
  input  logic [DataWidth-1:0] prdata_i,
  input  logic                 pready_i,
  input  logic                 pslverr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic                 we_q;
  logic [DataWidth-1:0] wdata_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;
  logic                 accept;
  logic                 misaligned;
  logic                 timeout_hit;

  assign accept     = (state_q == IDLE) && req_valid_i;
  assign misaligned = (req_addr_i[1:0] != 2'b00);

`ifdef APB_MGR_TIMEOUT_EN
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q;

  // Abort only when pready is still low on the last allowed ACCESS cycle; pready wins a tie.
  assign timeout_hit = (state_q == ACCESS) && !pready_i && (cnt_q == CntW'(TimeoutCycles - 1));

  // Wait-state counter: cleared in SETUP so it starts at 0 on the first ACCESS cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !pready_i) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout_hit        = 1'b0;
`endif

  // State register; reset drops psel/penable/rsp_valid immediately and abandons any transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/APB control outputs decoded from the current state.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = misaligned ? RESP : SETUP;
        end
      end
      SETUP: begin
        psel_o  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture on accept and response capture at the end of ACCESS; held otherwise
  // so the APB address/data lines do not toggle while the bus is idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr_i;
      we_q    <= req_we_i;
      wdata_q <= req_wdata_i;
      rdata_q <= '0;
      err_q   <= misaligned;
    end else if (state_q == ACCESS) begin
      if (pready_i) begin
        rdata_q <= (we_q || pslverr_i) ? '0 : prdata_i;
        err_q   <= pslverr_i;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign paddr_o     = addr_q;
  assign pwrite_o    = we_q;
  assign pwdata_o    = wdata_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
